// File: rtl/lsu.sv
// Load/store unit: turns one byte/half/word request into one or two word-indexed
// memory accesses with per-byte lane enables. Word-crossing accesses are split across
// two consecutive cycles. Load data is merged, sign/zero-extended and returned with a
// registered one-cycle rvalid_o pulse.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i / ready_o          request handshake (ready_o high only in idle)
//   we_i, size_i, unsigned_i request attributes (size 11 is illegal -> err_o)
//   addr_i, wdata_i          byte address, right-justified store data
//   rvalid_o, rdata_o, err_o registered completion
//   mem_*                    word-indexed memory port, combinational from state only
module lsu #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_write_o,
  output logic [3:0]        mem_b_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned WordW = ADDR_W - 2;

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StErr} state_e;

  state_e            state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [63:0]       buf_q;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [1:0]        off;
  logic [3:0]        mask;
  logic [7:0]        wide;
  logic              split;
  logic [WordW-1:0]  word;
  logic [WordW-1:0]  word_nxt;
  logic [31:0]       rot;
  logic [31:0]       lane_bits;
  logic [31:0]       rd_masked;
  logic [63:0]       merged;
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic              unused_merged;

  // Byte 7 of the merge window can never reach the 32-bit result.
  assign unused_merged = ^merged[63:56];

  always_comb begin
    off = addr_q[1:0];
    case (size_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    wide     = {4'b0000, mask} << off;
    split    = |wide[7:4];
    word     = addr_q[ADDR_W-1:2];
    word_nxt = word + 1'b1;  // wraps at the top of memory

    unique case (off)
      2'd0: rot = wdata_q;
      2'd1: rot = {wdata_q[23:0], wdata_q[31:24]};
      2'd2: rot = {wdata_q[15:0], wdata_q[31:16]};
      default: rot = {wdata_q[7:0], wdata_q[31:8]};
    endcase
  end

  // Memory port: purely a function of state and captured request.
  always_comb begin
    mem_write_o = 1'b0;
    mem_b_sel_o = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      StAcc0: begin
        mem_write_o = we_q;
        mem_b_sel_o = wide[3:0];
        mem_addr_o  = {2'b00, word};
        mem_wdata_o = rot;
      end
      StAcc1: begin
        mem_write_o = we_q;
        mem_b_sel_o = wide[7:4];
        mem_addr_o  = {2'b00, word_nxt};
        mem_wdata_o = rot;
      end
      default: ;
    endcase
  end

  // Load merge: the half being read this cycle comes straight from memory.
  always_comb begin
    lane_bits = {{8{mem_b_sel_o[3]}}, {8{mem_b_sel_o[2]}},
                 {8{mem_b_sel_o[1]}}, {8{mem_b_sel_o[0]}}};
    rd_masked = mem_rdata_i & lane_bits;
    if (state_q == StAcc1) merged = {rd_masked, buf_q[31:0]};
    else                   merged = {buf_q[63:32], rd_masked};

    unique case (off)
      2'd0: raw = merged[31:0];
      2'd1: raw = merged[39:8];
      2'd2: raw = merged[47:16];
      default: raw = merged[55:24];
    endcase

    case (size_q)
      2'b00:   ext = {{24{~uns_q & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{~uns_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            state_q <= (size_i == 2'b11) ? StErr : StAcc0;
          end
        end
        StAcc0: begin
          buf_q[31:0] <= rd_masked;
          if (split) begin
            state_q <= StAcc1;
          end else begin
            state_q  <= StIdle;
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? 32'h0 : ext;
          end
        end
        StAcc1: begin
          buf_q[63:32] <= rd_masked;
          state_q      <= StIdle;
          rvalid_q     <= 1'b1;
          rdata_q      <= we_q ? 32'h0 : ext;
        end
        default: begin
          state_q  <= StIdle;
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule
